mcpu_bus_if: RTL and testbench
==============================

# mcpu_bus_if

Parametrised memory/IO bus interface unit for the multicycle CPU. It sits between the CPU controller/datapath and the external memory/IO bus. It turns single load/store requests into bus cycles that are held until `MIO_ready`. Over the plain word-wide port it adds byte/half/word(/dword) sizing, byte-lane strobes, load sign/zero extension, alignment checking and a wait-state timeout.

## Interface
Parameters:
- `DATA_W`, 32: bus data width; legal values 32 or 64. `LANES = DATA_W/8`, `OFS_W = log2(LANES)`.
- `ADDR_W`, 32: byte address width.
- `TIMEOUT`, 16: maximum cycles in BUS without `MIO_ready` before the access aborts; must be ≥2.

Ports, CPU side:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  access request, sampled in IDLE only.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when `DATA_W=64`).
- `sext`  in  1  load sign-extend (1) or zero-extend (0).
- `addr`  in  ADDR_W  byte address.
- `wdata`  in  DATA_W  store data, right-aligned.
- `rdata`  out  DATA_W  extended load data; valid while `done`=1.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`: misaligned, illegal size, or timeout.
- `busy`  out  1  high in every state except IDLE.

Ports, bus side:
- `MIO_ready`  in  1  bus completes the access this cycle.
- `Data_in`  in  DATA_W  bus read data.
- `CPU_MIO`  out  1  bus cycle active.
- `mem_w`  out  1  write strobe; only ever high while `CPU_MIO`=1.
- `Addr_out`  out  ADDR_W  address, low OFS_W bits forced to 0.
- `Data_out`  out  DATA_W  lane-positioned store data.
- `be`  out  LANES  byte-lane enables.

## Operation
- FSM has three states: IDLE, BUS, RESP.
- **IDLE**
  - `req`=1 with a legal size and alignment: register `addr`, `we`, `size`, `sext` and lane-shifted `wdata`; compute `be`; go to BUS.
  - `req`=1 with an illegal size or misalignment: no bus cycle; set the error flag; go to RESP.
  - Misaligned means: half with `addr[0]`≠0, word with `addr[1:0]`≠0, dword with `addr[2:0]`≠0.
- **BUS**
  - `CPU_MIO`=1 and `mem_w`=registered `we`.
  - `Addr_out`, `Data_out` and `be` are held stable for the whole state.
  - `MIO_ready`=1: capture the lane-extracted and extended `Data_in` into `rdata` (for stores, `rdata` is 0); go to RESP.
  - Otherwise increment the wait counter. When the counter reaches TIMEOUT-1 and `MIO_ready`=0, set the error flag and go to RESP.
- **RESP**
  - `done`=1 and `err`=error flag.
  - Go to IDLE. `req` seen in RESP is ignored; the requester re-asserts it in IDLE.
- Lane rules
  - Write data is replicated across every lane group of the access size.
  - `be` is set for lanes `addr[OFS_W-1:0]` through `addr[OFS_W-1:0]+bytes-1`.
  - Read data: the selected lanes shift to bit 0, then extend per `sext`. Width is exactly DATA_W.
- On a timeout, `rdata`=0.

## Timing
- Every output is a register or decoded from the state register; no input→output combinational path.
- Minimum latency:
  - `req` sampled at edge T0.
  - BUS is held for cycle T0→T1; `MIO_ready` is sampled at edge T1.
  - `done` is high for the cycle after T1, i.e. 2 cycles after acceptance.
  - Each wait state adds 1 cycle.
- Error latency:
  - Misaligned request: `done`+`err` in the cycle after acceptance.
  - Timeout: `done`+`err` after exactly TIMEOUT cycles in BUS.
- Reset values: state IDLE, wait counter 0, and `done`, `err`, `busy`, `CPU_MIO`, `mem_w`, `be`, `Addr_out`, `Data_out`, `rdata` all 0.
- Reset mid-BUS: `CPU_MIO` and `mem_w` drop after the reset edge. No `done` is issued. A `MIO_ready` arriving in the same cycle as reset is discarded.
- `MIO_ready` outside BUS is ignored.

## Structure
- Package `mcpu_bus_pkg` holds:
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`;
  - state encodings `ST_IDLE`, `ST_BUS`, `ST_RESP`;
  - a function that returns the byte count for a size.
- Sub-module `mcpu_lane_align` is purely combinational and parametrised on DATA_W. It contains:
  - the store lane shifter and `be` generator;
  - the load lane extractor and extender;
  - the alignment check.
- `mcpu_bus_if` holds the FSM, the wait counter and the output registers.

## Test plan
- **Word store, zero wait**: DATA_W=32, `we`=1, `size`=10, `addr`=0x100, `wdata`=0xDEADBEEF, `MIO_ready`=1 in the first BUS cycle. Required: `Addr_out`=0x100, `be`=1111, `Data_out`=0xDEADBEEF, `mem_w`=1 for 1 cycle, then `done`=1 with `err`=0, 2 cycles after acceptance.
- **Signed byte load**: `addr`=0x203, `size`=00, `sext`=1, `Data_in`=0x80112233, ready after 3 waits. Required: `Addr_out`=0x200, `be`=1000, `rdata`=0xFFFFFF80, `done` 5 cycles after acceptance. Repeat with `sext`=0: `rdata`=0x00000080.
- **Half store**: `addr`=0x06, `wdata`=0x0000ABCD. Required: `be`=1100, `Data_out`=0xABCDABCD.
- **Misaligned access**: word access at `addr`=0x102. Required: `CPU_MIO` never asserted; `done`=`err`=1 the next cycle. Separately, `size`=11 with DATA_W=32 gives the same response.
- **Timeout**: TIMEOUT=4, `MIO_ready` held at 0. Required: BUS lasts exactly 4 cycles, then `done`=`err`=1 with `rdata`=0, then `busy`=0.
- **Reset mid-BUS**: assert `reset` during the 2nd wait cycle. Required: all outputs 0 after the edge, no `done`. Then repeat with DATA_W=64: a dword load at 0x08 gives `be`=0xFF.

Source files
------------

// File: rtl/mcpu_bus_pkg.sv
// rtl/mcpu_bus_pkg.sv - shared encodings and helpers for the multicycle CPU bus interface
package mcpu_bus_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic int size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_bytes = 1;
      SZ_H:    size_bytes = 2;
      SZ_W:    size_bytes = 4;
      default: size_bytes = 8;
    endcase
  endfunction

endpackage

// File: rtl/mcpu_lane_align.sv
// rtl/mcpu_lane_align.sv - byte-lane steering, strobes, load extension and alignment check
module mcpu_lane_align
  import mcpu_bus_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]                  req_ofs,
  input  logic [1:0]                  req_size,
  input  logic [DATA_W-1:0]           req_wdata,
  output logic [DATA_W-1:0]           st_data,
  output logic [DATA_W/8-1:0]         st_be,
  output logic                        req_bad,
  input  logic [$clog2(DATA_W/8)-1:0] ld_ofs,
  input  logic [1:0]                  ld_size,
  input  logic                        ld_sext,
  input  logic [DATA_W-1:0]           ld_raw,
  output logic [DATA_W-1:0]           ld_data
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS_W = $clog2(LANES);

  // A dword on a 32-bit bus never reaches the lanes; clamping keeps indices in range.
  function automatic int clamp_bytes(input logic [1:0] sz);
    int n;
    n = size_bytes(sz);
    return (n > LANES) ? LANES : n;
  endfunction

  always_comb begin
    int n;
    int ofs;
    st_data = '0;
    st_be   = '0;
    n       = clamp_bytes(req_size);
    ofs     = int'(req_ofs[OFS_W-1:0]);
    for (int i = 0; i < LANES; i++) begin
      st_data[i*8 +: 8] = req_wdata[(i % n)*8 +: 8];
      st_be[i]          = (i >= ofs) && (i < ofs + n);
    end
  end

  always_comb begin
    case (req_size)
      SZ_H:    req_bad = req_ofs[0];
      SZ_W:    req_bad = |req_ofs[1:0];
      SZ_D:    req_bad = (LANES < 8) || (|req_ofs);
      default: req_bad = 1'b0;
    endcase
  end

  logic [DATA_W-1:0] shifted;
  logic              fill;

  always_comb begin
    int nbits;
    ld_data = '0;
    nbits   = clamp_bytes(ld_size) * 8;
    shifted = ld_raw >> (int'(ld_ofs) * 8);
    case (ld_size)
      SZ_B:    fill = ld_sext & shifted[7];
      SZ_H:    fill = ld_sext & shifted[15];
      SZ_W:    fill = ld_sext & shifted[31];
      default: fill = ld_sext & shifted[DATA_W-1];
    endcase
    for (int j = 0; j < DATA_W; j++) begin
      ld_data[j] = (j < nbits) ? shifted[j] : fill;
    end
  end

endmodule

// File: rtl/mcpu_bus_if.sv
// rtl/mcpu_bus_if.sv - load/store to held bus-cycle converter with sizing, strobes and timeout
module mcpu_bus_if
  import mcpu_bus_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [1:0]          size,
  input  logic                sext,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                done,
  output logic                err,
  output logic                busy,
  input  logic                MIO_ready,
  input  logic [DATA_W-1:0]   Data_in,
  output logic                CPU_MIO,
  output logic                mem_w,
  output logic [ADDR_W-1:0]   Addr_out,
  output logic [DATA_W-1:0]   Data_out,
  output logic [DATA_W/8-1:0] be
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS_W = $clog2(LANES);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [LANES-1:0]  be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] st_data;
  logic [LANES-1:0]  st_be;
  logic              req_bad;
  logic [DATA_W-1:0] ld_data;

  mcpu_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane (
    .req_ofs   (addr[2:0]),
    .req_size  (size),
    .req_wdata (wdata),
    .st_data   (st_data),
    .st_be     (st_be),
    .req_bad   (req_bad),
    .ld_ofs    (ofs_q),
    .ld_size   (size_q),
    .ld_sext   (sext_q),
    .ld_raw    (Data_in),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = req_bad ? ST_RESP : ST_BUS;
      ST_BUS:  if (MIO_ready || (cnt_q == CNT_LAST)) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    CPU_MIO = (state_q == ST_BUS);
    mem_w   = (state_q == ST_BUS) && we_q;
    done    = (state_q == ST_RESP);
    err     = (state_q == ST_RESP) && err_q;
  end

  // Bus-facing fields are latched only on a legal accept so they stay frozen through BUS.
  always_comb begin
    cnt_d   = '0;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    ofs_d   = ofs_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          rdata_d = '0;
          err_d   = req_bad;
          if (!req_bad) begin
            we_d   = we;
            size_d = size;
            sext_d = sext;
            ofs_d  = addr[OFS_W-1:0];
            addr_d = {addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            dout_d = st_data;
            be_d   = st_be;
          end
        end
      end
      ST_BUS: begin
        if (MIO_ready) begin
          rdata_d = we_q ? '0 : ld_data;
        end else if (cnt_q == CNT_LAST) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      sext_q  <= 1'b0;
      ofs_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      ofs_q   <= ofs_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rdata    = rdata_q;
  assign Addr_out = addr_q;
  assign Data_out = dout_q;
  assign be       = be_q;

endmodule

// File: tb/tb_mcpu_bus_if.sv
// tb/tb_mcpu_bus_if.sv - scoreboard bench for mcpu_bus_if on 32-bit and 64-bit buses
module tb_mcpu_bus_if;
  import mcpu_bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        req32, we32, sext32, rdy32;
  logic [1:0]  size32;
  logic [31:0] addr32, wdata32, din32;
  logic [31:0] rdata32, aout32, dout32;
  logic        done32, err32, busy32, mio32, memw32;
  logic [3:0]  be32;

  logic        req64, we64, sext64, rdy64;
  logic [1:0]  size64;
  logic [31:0] addr64, aout64;
  logic [63:0] wdata64, din64, rdata64, dout64;
  logic        done64, err64, busy64, mio64, memw64;
  logic [7:0]  be64;

  mcpu_bus_if #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
    .clk(clk), .reset(reset), .req(req32), .we(we32), .size(size32), .sext(sext32),
    .addr(addr32), .wdata(wdata32), .rdata(rdata32), .done(done32), .err(err32),
    .busy(busy32), .MIO_ready(rdy32), .Data_in(din32), .CPU_MIO(mio32), .mem_w(memw32),
    .Addr_out(aout32), .Data_out(dout32), .be(be32)
  );

  mcpu_bus_if #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) u_dut64 (
    .clk(clk), .reset(reset), .req(req64), .we(we64), .size(size64), .sext(sext64),
    .addr(addr64), .wdata(wdata64), .rdata(rdata64), .done(done64), .err(err64),
    .busy(busy64), .MIO_ready(rdy64), .Data_in(din64), .CPU_MIO(mio64), .mem_w(memw64),
    .Addr_out(aout64), .Data_out(dout64), .be(be64)
  );

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          nbus;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
    we32 = w; size32 = sz; sext32 = sx; addr32 = a; wdata32 = wd; req32 = 1'b1;
    tick();
    req32 = 1'b0;
  endtask

  task automatic issue64(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [63:0] wd);
    we64 = w; size64 = sz; sext64 = sx; addr64 = a; wdata64 = wd; req64 = 1'b1;
    tick();
    req64 = 1'b0;
  endtask

  // Drives MIO_ready after `waits` wait states; counts BUS cycles, bounded.
  task automatic bus_run32(input int waits, input logic [31:0] din, output int nbus,
                           output logic stable, output int mw);
    logic [31:0] a0, d0;
    logic [3:0]  b0;
    a0 = aout32; d0 = dout32; b0 = be32;
    nbus = 0; stable = 1'b1; mw = 0; din32 = din;
    while (mio32 === 1'b1 && nbus < 40) begin
      if (aout32 !== a0 || dout32 !== d0 || be32 !== b0) stable = 1'b0;
      if (memw32 === 1'b1) mw++;
      rdy32 = (nbus == waits);
      nbus++;
      tick();
    end
    rdy32 = 1'b0;
  endtask

  function automatic logic [31:0] model_ld(input logic [1:0] sz, input logic sx,
                                           input logic [1:0] ofs, input logic [31:0] din);
    logic [31:0] v;
    v = din >> (8 * ofs);
    case (sz)
      SZ_B:    model_ld = {{24{sx & v[7]}}, v[7:0]};
      SZ_H:    model_ld = {{16{sx & v[15]}}, v[15:0]};
      default: model_ld = v;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    vectors++;
    if ({done32, err32, busy32, mio32, memw32} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ctl32 got %b want 00000", {done32, err32, busy32, mio32, memw32});
    end
    vectors++;
    if ({aout32, dout32, rdata32, be32} !== 100'b0) begin
      miscompares++; $display("FAIL reset_data32 got %h %h %h %h want 0", aout32, dout32, rdata32, be32);
    end
    vectors++;
    if ({done64, err64, busy64, mio64, memw64, be64, aout64, dout64, rdata64} !== 173'b0) begin
      miscompares++; $display("FAIL reset_all64 got be=%h addr=%h dout=%h rdata=%h busy=%b", be64, aout64, dout64, rdata64, busy64);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_word_store();
    exp_t e; int nb, mw; logic st;
    sb.push_back('{err: 1'b0, rdata: 64'h0, nbus: 1});
    issue32(1'b1, SZ_W, 1'b0, 32'h100, 32'hDEADBEEF);
    vectors++;
    if ({aout32, be32, dout32, memw32} !== {32'h100, 4'hF, 32'hDEADBEEF, 1'b1}) begin
      miscompares++; $display("FAIL word_store_bus got addr=%h be=%b data=%h mw=%b want 100 1111 deadbeef 1", aout32, be32, dout32, memw32);
    end
    bus_run32(0, 32'h0, nb, st, mw);
    e = sb.pop_front();
    vectors++;
    if (nb !== e.nbus || mw !== 1 || st !== 1'b1) begin
      miscompares++; $display("FAIL word_store_cycles got bus=%0d memw=%0d stable=%b want %0d 1 1", nb, mw, st, e.nbus);
    end
    vectors++;
    if ({done32, err32, rdata32} !== {1'b1, e.err, e.rdata[31:0]}) begin
      miscompares++; $display("FAIL word_store_resp got done=%b err=%b rdata=%h want 1 %b %h", done32, err32, rdata32, e.err, e.rdata[31:0]);
    end
    tick();
    vectors++;
    if ({busy32, done32} !== 2'b00) begin
      miscompares++; $display("FAIL word_store_idle got busy=%b done=%b want 0 0", busy32, done32);
    end
  endtask

  task automatic test_byte_load();
    exp_t e; int nb, mw; logic st, sx; logic [31:0] want;
    for (int k = 0; k < 2; k++) begin
      sx   = (k == 0);
      want = sx ? 32'hFFFFFF80 : 32'h00000080;
      sb.push_back('{err: 1'b0, rdata: {32'h0, want}, nbus: 4});
      issue32(1'b0, SZ_B, sx, 32'h203, 32'h0);
      vectors++;
      if ({aout32, be32, memw32} !== {32'h200, 4'b1000, 1'b0}) begin
        miscompares++; $display("FAIL byte_load_bus sext=%b got addr=%h be=%b mw=%b want 200 1000 0", sx, aout32, be32, memw32);
      end
      bus_run32(3, 32'h80112233, nb, st, mw);
      e = sb.pop_front();
      vectors++;
      if (nb !== e.nbus || st !== 1'b1) begin
        miscompares++; $display("FAIL byte_load_cycles sext=%b got bus=%0d stable=%b want %0d 1", sx, nb, st, e.nbus);
      end
      vectors++;
      if ({done32, err32, rdata32} !== {1'b1, e.err, e.rdata[31:0]}) begin
        miscompares++; $display("FAIL byte_load_resp sext=%b got done=%b err=%b rdata=%h want 1 0 %h", sx, done32, err32, rdata32, e.rdata[31:0]);
      end
      tick();
    end
  endtask

  task automatic test_half_store();
    exp_t e; int nb, mw; logic st;
    sb.push_back('{err: 1'b0, rdata: 64'h0, nbus: 2});
    issue32(1'b1, SZ_H, 1'b0, 32'h06, 32'h0000ABCD);
    vectors++;
    if ({aout32, be32, dout32} !== {32'h4, 4'b1100, 32'hABCDABCD}) begin
      miscompares++; $display("FAIL half_store_bus got addr=%h be=%b data=%h want 4 1100 abcdabcd", aout32, be32, dout32);
    end
    bus_run32(1, 32'h0, nb, st, mw);
    e = sb.pop_front();
    vectors++;
    if (nb !== e.nbus || mw !== e.nbus || {done32, err32} !== 2'b10) begin
      miscompares++; $display("FAIL half_store_resp got bus=%0d memw=%0d done=%b err=%b want %0d %0d 1 0", nb, mw, done32, err32, e.nbus, e.nbus);
    end
    tick();
  endtask

  task automatic test_misaligned();
    exp_t e; logic [1:0] sz; logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin sz = SZ_W; a = 32'h102; end
        1:       begin sz = SZ_D; a = 32'h100; end
        default: begin sz = SZ_H; a = 32'h101; end
      endcase
      sb.push_back('{err: 1'b1, rdata: 64'h0, nbus: 0});
      we32 = 1'b0; size32 = sz; addr32 = a; din32 = 32'hFFFFFFFF; req32 = 1'b1;
      tick();
      e = sb.pop_front();
      vectors++;
      if ({mio32, done32, err32, rdata32} !== {1'b0, 1'b1, e.err, e.rdata[31:0]}) begin
        miscompares++; $display("FAIL misalign_resp case=%0d got mio=%b done=%b err=%b rdata=%h want 0 1 1 0", k, mio32, done32, err32, rdata32);
      end
      tick();
      vectors++;
      if ({busy32, mio32} !== 2'b00) begin
        miscompares++; $display("FAIL resp_ignores_req case=%0d got busy=%b mio=%b want 0 0", k, busy32, mio32);
      end
      req32 = 1'b0;
      tick();
    end
  endtask

  task automatic test_timeout();
    exp_t e; int nb, mw; logic st;
    sb.push_back('{err: 1'b1, rdata: 64'h0, nbus: 4});
    issue32(1'b0, SZ_W, 1'b0, 32'h40, 32'h0);
    bus_run32(1000, 32'hFFFFFFFF, nb, st, mw);
    e = sb.pop_front();
    vectors++;
    if (nb !== e.nbus) begin
      miscompares++; $display("FAIL timeout_len got %0d bus cycles want %0d", nb, e.nbus);
    end
    vectors++;
    if ({done32, err32, rdata32} !== {1'b1, e.err, e.rdata[31:0]}) begin
      miscompares++; $display("FAIL timeout_resp got done=%b err=%b rdata=%h want 1 1 0", done32, err32, rdata32);
    end
    tick();
    vectors++;
    if (busy32 !== 1'b0) begin
      miscompares++; $display("FAIL timeout_idle got busy=%b want 0", busy32);
    end
  endtask

  task automatic test_reset_mid_bus();
    logic seen;
    issue32(1'b1, SZ_W, 1'b0, 32'h80, 32'h55AA55AA);
    rdy32 = 1'b0;
    tick();
    vectors++;
    if ({mio32, memw32} !== 2'b11) begin
      miscompares++; $display("FAIL mid_bus32_pre got mio=%b mw=%b want 1 1", mio32, memw32);
    end
    reset = 1'b1; rdy32 = 1'b1; din32 = 32'h12345678;
    tick();
    reset = 1'b0; rdy32 = 1'b0;
    vectors++;
    if ({done32, err32, busy32, mio32, memw32, aout32, dout32, rdata32, be32} !== 105'b0) begin
      miscompares++; $display("FAIL mid_bus32_reset got mio=%b mw=%b done=%b addr=%h data=%h rdata=%h be=%b want all 0", mio32, memw32, done32, aout32, dout32, rdata32, be32);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done32 !== 1'b0 || busy32 !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL mid_bus32_nodone got activity=%b want 0", seen);
    end

    issue64(1'b0, SZ_D, 1'b0, 32'h08, 64'h0);
    vectors++;
    if ({be64, aout64, mio64} !== {8'hFF, 32'h08, 1'b1}) begin
      miscompares++; $display("FAIL mid_bus64_pre got be=%h addr=%h mio=%b want ff 8 1", be64, aout64, mio64);
    end
    tick();
    reset = 1'b1; rdy64 = 1'b1; din64 = 64'hFEEDFACE12345678;
    tick();
    reset = 1'b0; rdy64 = 1'b0;
    vectors++;
    if ({done64, err64, busy64, mio64, memw64, be64, aout64, dout64, rdata64} !== 173'b0) begin
      miscompares++; $display("FAIL mid_bus64_reset got mio=%b done=%b be=%h rdata=%h want all 0", mio64, done64, be64, rdata64);
    end
    tick();
    vectors++;
    if (done64 !== 1'b0) begin
      miscompares++; $display("FAIL mid_bus64_nodone got done=%b want 0", done64);
    end
  endtask

  task automatic test_bus64();
    exp_t e; logic w, sx; logic [1:0] sz; logic [31:0] a; logic [63:0] wd, din, want_d;
    logic [7:0] want_be; int nb;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin w = 1'b0; sz = SZ_D; sx = 1'b0; a = 32'h08; wd = 64'h0;
                 din = 64'h0123456789ABCDEF; want_be = 8'hFF; want_d = 64'h0; end
        1: begin w = 1'b1; sz = SZ_W; sx = 1'b0; a = 32'h0C; wd = 64'h00000000CAFEF00D;
                 din = 64'h0; want_be = 8'hF0; want_d = 64'hCAFEF00DCAFEF00D; end
        default: begin w = 1'b0; sz = SZ_H; sx = 1'b1; a = 32'h0E; wd = 64'h0;
                 din = 64'h8001000000000000; want_be = 8'hC0; want_d = 64'h0; end
      endcase
      sb.push_back('{err: 1'b0, nbus: 1,
                     rdata: (k == 0) ? 64'h0123456789ABCDEF : (k == 1) ? 64'h0 : 64'hFFFFFFFFFFFF8001});
      issue64(w, sz, sx, a, wd);
      vectors++;
      if ({be64, aout64, memw64} !== {want_be, 32'h08, w}) begin
        miscompares++; $display("FAIL bus64_lanes case=%0d got be=%h addr=%h mw=%b want %h 8 %b", k, be64, aout64, memw64, want_be, w);
      end
      if (w) begin
        vectors++;
        if (dout64 !== want_d) begin
          miscompares++; $display("FAIL bus64_wdata got %h want %h", dout64, want_d);
        end
      end
      din64 = din; rdy64 = 1'b1; nb = 0;
      while (mio64 === 1'b1 && nb < 40) begin nb++; tick(); end
      rdy64 = 1'b0;
      e = sb.pop_front();
      vectors++;
      if (nb !== e.nbus || {done64, err64, rdata64} !== {1'b1, e.err, e.rdata}) begin
        miscompares++; $display("FAIL bus64_resp case=%0d got bus=%0d done=%b err=%b rdata=%h want %0d 1 0 %h", k, nb, done64, err64, rdata64, e.nbus, e.rdata);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int nb, mw, n, waits; logic st, w, sx, bad;
    logic [1:0] sz; logic [31:0] a, wd, din, want_dout; logic [3:0] want_be;
    for (int i = 0; i < 16; i++) begin
      w = 1'($urandom_range(0, 1)); sx = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3)); a = $urandom & 32'hFFF;
      wd = $urandom; din = $urandom; waits = $urandom_range(0, 2);
      bad = (sz == SZ_H && a[0]) || (sz == SZ_W && a[1:0] != 2'b00) || (sz == SZ_D);
      n = (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
      want_be = 4'(((1 << n) - 1) << a[1:0]);
      want_dout = (sz == SZ_B) ? {4{wd[7:0]}} : (sz == SZ_H) ? {2{wd[15:0]}} : wd;
      sb.push_back('{err: bad, nbus: bad ? 0 : waits + 1,
                     rdata: {32'h0, (bad || w) ? 32'h0 : model_ld(sz, sx, a[1:0], din)}});
      issue32(w, sz, sx, a, wd);
      if (!bad) begin
        vectors++;
        if ({be32, dout32, aout32} !== {want_be, want_dout, a & 32'hFFFFFFFC}) begin
          miscompares++; $display("FAIL b2b_lanes i=%0d got be=%b data=%h addr=%h want %b %h %h", i, be32, dout32, aout32, want_be, want_dout, a & 32'hFFFFFFFC);
        end
      end
      bus_run32(waits, din, nb, st, mw);
      e = sb.pop_front();
      vectors++;
      if (nb !== e.nbus || st !== 1'b1 || mw !== (w ? nb : 0)) begin
        miscompares++; $display("FAIL b2b_cycles i=%0d got bus=%0d stable=%b memw=%0d want %0d 1 %0d", i, nb, st, mw, e.nbus, w ? nb : 0);
      end
      vectors++;
      if ({done32, err32, rdata32} !== {1'b1, e.err, e.rdata[31:0]}) begin
        miscompares++; $display("FAIL b2b_resp i=%0d got done=%b err=%b rdata=%h want 1 %b %h", i, done32, err32, rdata32, e.err, e.rdata[31:0]);
      end
      tick();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1;
    req32 = 1'b0; we32 = 1'b0; size32 = SZ_B; sext32 = 1'b0; addr32 = '0; wdata32 = '0;
    rdy32 = 1'b0; din32 = '0;
    req64 = 1'b0; we64 = 1'b0; size64 = SZ_B; sext64 = 1'b0; addr64 = '0; wdata64 = '0;
    rdy64 = 1'b0; din64 = '0;
    test_reset();
    test_word_store();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_bus();
    test_bus64();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
